// File: rtl/conv2d_stream.sv
// Streaming 2-D valid-mode convolution: buffers one N x N frame, then MACs one tap per cycle per window.
// Define CONV_SAT_EN to clamp results to the DW range; otherwise results wrap (low DW bits of acc).
module conv2d_stream #(
  parameter int DW     = 13,
  parameter int N      = 6,
  parameter int M      = 3,
  parameter int STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_we,
  input  logic [$clog2(M*M)-1:0]  w_addr,
  input  logic [DW-1:0]           w_data,
  input  logic                    start,
  input  logic                    px_valid,
  output logic                    px_ready,
  input  logic [DW-1:0]           px_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic                    busy,
  output logic                    done
);
  localparam int ACC_W = 2*DW + $clog2(M*M);
  localparam int NPIX  = N*N;
  localparam int NTAP  = M*M;
  localparam int LASTO = N - M;
  localparam int AW    = $clog2(NPIX);
  localparam int WAW   = $clog2(NTAP);
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [AW-1:0] PX_LAST = AW'(NPIX - 1);
  localparam logic [CW-1:0] K_LAST  = CW'(M - 1);
  localparam logic [CW-1:0] STEP    = CW'(STRIDE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  logic [2:0]               state;
  logic signed [DW-1:0]     wmem [NTAP];
  logic signed [DW-1:0]     amem [NPIX];
  logic [AW-1:0]            px_cnt;
  logic [CW-1:0]            r, c, p, q;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [2*DW-1:0]   prod;
  logic [AW-1:0]            a_idx;
  logic [WAW-1:0]           w_idx;
  logic [DW-1:0]            res, out_q;
  logic                     last_c, last_r, idle_like;

  always_comb begin
    a_idx   = AW'((32'(r) + 32'(p)) * N + 32'(c) + 32'(q));
    w_idx   = WAW'(32'(p) * M + 32'(q));
    prod    = amem[a_idx] * wmem[w_idx];
    acc_nxt = acc + ACC_W'(prod);
`ifdef CONV_SAT_EN
    if (acc_nxt > SAT_MAX)      res = SAT_MAX[DW-1:0];
    else if (acc_nxt < SAT_MIN) res = SAT_MIN[DW-1:0];
    else                        res = acc_nxt[DW-1:0];
`else
    res = acc_nxt[DW-1:0];
`endif
    // A window origin is the last in its row/column once another step would overrun the frame.
    last_c    = (32'(c) + STRIDE) > LASTO;
    last_r    = (32'(r) + STRIDE) > LASTO;
    idle_like = (state == S_IDLE) || (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      px_cnt <= '0;
      r      <= '0;
      c      <= '0;
      p      <= '0;
      q      <= '0;
      acc    <= '0;
      out_q  <= '0;
      for (int i = 0; i < NTAP; i++) wmem[i] <= '0;
      for (int i = 0; i < NPIX; i++) amem[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (w_we && (32'(w_addr) < NTAP)) wmem[w_addr] <= w_data;
          if (start) begin
            state  <= S_LOAD;
            px_cnt <= '0;
            r      <= '0;
            c      <= '0;
            p      <= '0;
            q      <= '0;
          end
        end
        S_LOAD: begin
          if (px_valid) begin
            amem[px_cnt] <= px_data;
            px_cnt       <= px_cnt + AW'(1);
            if (px_cnt == PX_LAST) begin
              state <= S_MAC;
              acc   <= '0;
            end
          end
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (q == K_LAST) begin
            q <= '0;
            if (p == K_LAST) begin
              p     <= '0;
              out_q <= res;
              state <= S_EMIT;
            end else begin
              p <= p + CW'(1);
            end
          end else begin
            q <= q + CW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            acc <= '0;
            if (last_c) begin
              c <= '0;
              if (last_r) begin
                state <= S_DONE;
              end else begin
                r     <= r + STEP;
                state <= S_MAC;
              end
            end else begin
              c     <= c + STEP;
              state <= S_MAC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a raised valid and its data hold until that edge, and ready never depends on valid.
  assign px_ready  = (state == S_LOAD);
  assign out_valid = (state == S_EMIT);
  assign out_data  = out_q;
  assign busy      = !idle_like;
  assign done      = (state == S_DONE);
endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream: a STRIDE=1 and a STRIDE=2 instance share all inputs.
module tb_conv2d_stream;
  localparam int DW = 13;
  localparam int N  = 6;
  localparam int M  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_we = 1'b0;
  logic [3:0]    w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          start = 1'b0;
  logic          px_valid = 1'b0;
  logic [DW-1:0] px_data = '0;
  logic          out_ready = 1'b0;

  logic          a_px_ready, a_out_valid, a_busy, a_done;
  logic [DW-1:0] a_out_data;
  logic          b_px_ready, b_out_valid, b_busy, b_done;
  logic [DW-1:0] b_out_data;

  int errors = 0;
  int checks = 0;
  int wtab [9] = '{-2, 0, 1, -1, 1, 0, 1, -2, 1};

  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  logic [DW-1:0] got_a [$];
  logic [DW-1:0] got_b [$];
  logic [DW-1:0] hold_a, hold_b;
  bit            hv_a = 0, hv_b = 0;

  always #5 clk = ~clk;

  conv2d_stream #(.DW(DW), .N(N), .M(M), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .start(start),
    .px_valid(px_valid), .px_ready(a_px_ready), .px_data(px_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .busy(a_busy), .done(a_done)
  );

  conv2d_stream #(.DW(DW), .N(N), .M(M), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .start(start),
    .px_valid(px_valid), .px_ready(b_px_ready), .px_data(px_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collect accepted results and check data stability while stalled.
  always @(negedge clk) begin
    if (a_out_valid) begin
      if (hv_a) check("stable_a", a_out_data, hold_a);
      hold_a = a_out_data;
      hv_a   = !out_ready;
      if (out_ready) got_a.push_back(a_out_data);
    end else begin
      hv_a = 0;
    end
  end

  always @(negedge clk) begin
    if (b_out_valid) begin
      if (hv_b) check("stable_b", b_out_data, hold_b);
      hold_b = b_out_data;
      hv_b   = !out_ready;
      if (out_ready) got_b.push_back(b_out_data);
    end else begin
      hv_b = 0;
    end
  end

  function automatic logic [DW-1:0] pix(input int mode, input int i);
    case (mode)
      0:       return DW'(1);
      1:       return DW'(i);
      default: return DW'(4095);
    endcase
  endfunction

  task automatic write_weights(input bit all_max, input bit start_last);
    for (int i = 0; i < 9; i++) begin
      w_we   = 1'b1;
      w_addr = 4'(i);
      w_data = all_max ? DW'(4095) : DW'(wtab[i]);
      start  = start_last && (i == 8);
      tick();
    end
    w_we  = 1'b0;
    start = 1'b0;
  endtask

  task automatic load_frame(input int mode, input bit toggle, input bit do_start);
    int cnt = 0;
    int cyc = 0;
    bit acc;
    got_a.delete();
    got_b.delete();
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    while (cnt < N*N && cyc < 1000) begin
      px_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      px_data  = pix(mode, cnt);
      acc      = px_valid && a_px_ready;
      tick();
      cyc++;
      if (acc) cnt++;
    end
    px_valid = 1'b0;
    check("load_count", DW'(cnt), DW'(N*N));
    check("px_ready_after_load", DW'(a_px_ready), DW'(0));
  endtask

  task automatic drain(input bit stall);
    int cyc = 0;
    int stall_cnt = 0;
    while (!(a_done && b_done) && cyc < 3000) begin
      w_we   = (cyc == 3);
      w_addr = '0;
      w_data = DW'(100);
      start  = (cyc == 5);
      out_ready = stall ? (a_out_valid && stall_cnt >= 5) : 1'b1;
      if (a_out_valid) stall_cnt = out_ready ? 0 : stall_cnt + 1;
      tick();
      cyc++;
    end
    w_we = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    check("done_a", DW'(a_done), DW'(1));
    check("done_b", DW'(b_done), DW'(1));
    check("busy_a_done", DW'(a_busy), DW'(0));
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s_cnt_a", tag), DW'(got_a.size()), DW'(exp_a.size()));
    check($sformatf("%s_cnt_b", tag), DW'(got_b.size()), DW'(exp_b.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check($sformatf("%s_a%0d", tag, i), got_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got_b[i], exp_b[i]);
  endtask

  task automatic fill_const(input int v);
    exp_a.delete();
    exp_b.delete();
    for (int i = 0; i < 16; i++) exp_a.push_back(DW'(v));
    for (int i = 0; i < 4; i++) exp_b.push_back(DW'(v));
  endtask

  task automatic fill_ramp();
    exp_a.delete();
    exp_b.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp_a.push_back(DW'(3 - (6*r + c)));
    exp_b.push_back(DW'(3));
    exp_b.push_back(DW'(1));
    exp_b.push_back(DW'(-9));
    exp_b.push_back(DW'(-11));
  endtask

  initial begin
    int cyc;
    #2 rst = 1'b0;
    #1;
    check("rst_px_ready", DW'(a_px_ready), DW'(0));
    check("rst_out_valid", DW'(a_out_valid), DW'(0));
    check("rst_busy", DW'(a_busy), DW'(0));
    check("rst_done", DW'(a_done), DW'(0));
    check("rst_out_data", a_out_data, DW'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Frame 1: last weight written on the same edge as start; all-ones pixels.
    write_weights(1'b0, 1'b1);
    check("busy_after_start", DW'(a_busy), DW'(1));
    check("px_ready_load", DW'(a_px_ready), DW'(1));
    load_frame(0, 1'b0, 1'b0);
    drain(1'b0);
    fill_const(-1);
    compare("t1");

    // Frame 2: ramp pixels, restarted from DONE.
    load_frame(1, 1'b0, 1'b1);
    drain(1'b0);
    fill_ramp();
    compare("t2");

    // Frame 3: maximal weights and pixels.
    write_weights(1'b1, 1'b0);
    load_frame(2, 1'b0, 1'b1);
    drain(1'b0);
`ifdef CONV_SAT_EN
    fill_const(4095);
`else
    fill_const(9);
`endif
    compare("t3");

    // Frame 4: ramp with toggling px_valid and stalled output.
    write_weights(1'b0, 1'b0);
    load_frame(1, 1'b1, 1'b1);
    drain(1'b1);
    fill_ramp();
    compare("t4");

    // Reset mid-MAC of window 5.
    load_frame(1, 1'b0, 1'b1);
    out_ready = 1'b1;
    cyc = 0;
    while (got_a.size() < 5 && cyc < 2000) begin
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t6_busy_pre", DW'(a_busy), DW'(1));
    check("t6_held_pre", a_out_data, DW'(-3));
    rst = 1'b0;
    #1;
    check("t6_busy", DW'(a_busy), DW'(0));
    check("t6_out_valid", DW'(a_out_valid), DW'(0));
    check("t6_out_data", a_out_data, DW'(0));
    check("t6_done_b", DW'(b_done), DW'(0));
    tick();
    rst = 1'b1;
    tick();
    check("t6_idle_px_ready", DW'(a_px_ready), DW'(0));
    check("t6_idle_busy", DW'(a_busy), DW'(0));
    load_frame(0, 1'b0, 1'b1);
    drain(1'b0);
    fill_const(0);
    compare("t6z");
    write_weights(1'b0, 1'b0);
    load_frame(0, 1'b0, 1'b1);
    drain(1'b0);
    fill_const(-1);
    compare("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
